// File: rtl/fsm_min_sec_counter.sv
// Minute/second timekeeping stage: load/run FSM with hour_carry rollover pulse.
// Define SEC_TICK_PRESCALE_EN to derive the second tick from clk via CLK_DIV.
module fsm_min_sec_counter #(
  parameter int CNT_W   = 6,
  parameter int MAX_SEC = 59,
  parameter int MAX_MIN = 59,
  parameter int CLK_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             time_load,
  input  logic [CNT_W-1:0] sec_in,
  input  logic [CNT_W-1:0] min_in,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] min_count,
  output logic             hour_carry,
  output logic             running
);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOAD = 3'd1,
    S_RUN       = 3'd2
  } state_t;

  localparam logic [CNT_W-1:0] SEC_TOP = CNT_W'(MAX_SEC);
  localparam logic [CNT_W-1:0] MIN_TOP = CNT_W'(MAX_MIN);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] sec_n;
  logic [CNT_W-1:0] min_n;
  logic             carry_n;
  logic             tick;
  logic [CNT_W-1:0] sec_ld;
  logic [CNT_W-1:0] min_ld;

  assign sec_ld  = (sec_in > SEC_TOP) ? SEC_TOP : sec_in;
  assign min_ld  = (min_in > MIN_TOP) ? MIN_TOP : min_in;
  assign running = (state == S_RUN);

`ifdef SEC_TICK_PRESCALE_EN
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          load_ok;

  assign load_ok = time_load &&
                   (state == S_WAIT_LOAD || state == S_RUN);
  assign tick    = (state == S_RUN) && (pre_cnt == PRE_TOP);

  // Cleared on load so the first tick lands CLK_DIV cycles after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (load_ok) begin
      pre_cnt <= '0;
    end else if (state == S_RUN) begin
      if (pre_cnt == PRE_TOP)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + 1'b1;
    end
  end

  logic unused_tick_in;
  assign unused_tick_in = tick_in;
`else
  assign tick = tick_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RESET;
      sec_count  <= '0;
      min_count  <= '0;
      hour_carry <= 1'b0;
    end else begin
      state      <= state_n;
      sec_count  <= sec_n;
      min_count  <= min_n;
      hour_carry <= carry_n;
    end
  end

  always_comb begin
    state_n = state;
    sec_n   = sec_count;
    min_n   = min_count;
    carry_n = 1'b0;
    case (state)
      S_RESET: begin
        state_n = S_WAIT_LOAD;
        sec_n   = '0;
        min_n   = '0;
      end
      S_WAIT_LOAD: begin
        sec_n = '0;
        min_n = '0;
        if (time_load) begin
          state_n = S_RUN;
          sec_n   = sec_ld;
          min_n   = min_ld;
        end
      end
      S_RUN: begin
        // A load takes priority and swallows a coincident tick.
        if (time_load) begin
          sec_n = sec_ld;
          min_n = min_ld;
        end else if (tick) begin
          if (sec_count < SEC_TOP) begin
            sec_n = sec_count + 1'b1;
          end else begin
            sec_n = '0;
            if (min_count < MIN_TOP) begin
              min_n = min_count + 1'b1;
            end else begin
              min_n   = '0;
              carry_n = 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = S_RESET;
        sec_n   = '0;
        min_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_min_sec_counter.sv
// Directed checks for fsm_min_sec_counter: reset, load, carries, priority.
// Covers the prescaled tick path when SEC_TICK_PRESCALE_EN is defined.
module tb_fsm_min_sec_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       time_load;
  logic [5:0] sec_in;
  logic [5:0] min_in;
  logic [5:0] sec_count;
  logic [5:0] min_count;
  logic       hour_carry;
  logic       running;

  int checks = 0;
  int errors = 0;

  fsm_min_sec_counter #(
    .CNT_W(6), .MAX_SEC(59), .MAX_MIN(59), .CLK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in),
    .time_load(time_load), .sec_in(sec_in), .min_in(min_in),
    .sec_count(sec_count), .min_count(min_count),
    .hour_carry(hour_carry), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tl;
    logic       tk;
    logic [5:0] si;
    logic [5:0] mi;
    logic [5:0] es;
    logic [5:0] em;
    logic       ec;
    logic       er;
  } vec_t;

  task automatic chk(input string name, input logic [5:0] es,
                     input logic [5:0] em, input logic ec,
                     input logic er);
    checks++;
    if ({sec_count, min_count, hour_carry, running} !== {es, em, ec, er}) begin
      errors++;
      $display("FAIL %s: got sec=%0d min=%0d carry=%b run=%b, want sec=%0d min=%0d carry=%b run=%b",
               name, sec_count, min_count, hour_carry, running,
               es, em, ec, er);
    end
  endtask

  task automatic step(input logic tl, input logic tk,
                      input logic [5:0] si, input logic [5:0] mi);
    @(negedge clk);
    time_load = tl;
    tick_in   = tk;
    sec_in    = si;
    min_in    = mi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_async", 6'd0, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vt [$];

  initial begin
    rst       = 1'b1;
    tick_in   = 1'b0;
    time_load = 1'b0;
    sec_in    = '0;
    min_in    = '0;
    #12;
    chk("reset_init", 6'd0, 6'd0, 1'b0, 1'b0);
    rst = 1'b0;

`ifndef SEC_TICK_PRESCALE_EN
    vt.push_back('{0, 1,  0,  0,  0,  0, 0, 0}); // RESET -> WAIT
    vt.push_back('{0, 1,  0,  0,  0,  0, 0, 0}); // tick ignored
    vt.push_back('{1, 0,  5,  7,  5,  7, 0, 1});
    vt.push_back('{0, 1,  0,  0,  6,  7, 0, 1});
    vt.push_back('{0, 0,  0,  0,  6,  7, 0, 1});
    vt.push_back('{1, 0, 10,  3, 10,  3, 0, 1});
    vt.push_back('{0, 1,  0,  0, 11,  3, 0, 1});
    vt.push_back('{1, 0, 59, 20, 59, 20, 0, 1});
    vt.push_back('{0, 1,  0,  0,  0, 21, 0, 1});
    vt.push_back('{1, 0, 59, 59, 59, 59, 0, 1});
    vt.push_back('{0, 0,  0,  0, 59, 59, 0, 1});
    vt.push_back('{0, 1,  0,  0,  0,  0, 1, 1});
    vt.push_back('{0, 0,  0,  0,  0,  0, 0, 1});
    vt.push_back('{1, 0, 59, 59, 59, 59, 0, 1});
    vt.push_back('{1, 0,  0,  0,  0,  0, 0, 1}); // load, no carry
    vt.push_back('{1, 1, 63, 60, 59, 59, 0, 1}); // clamp + priority
    vt.push_back('{1, 1, 40, 63, 40, 59, 0, 1});
    vt.push_back('{0, 1,  0,  0, 41, 59, 0, 1});
    vt.push_back('{1, 0, 34, 12, 34, 12, 0, 1});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].tl, vt[i].tk, vt[i].si, vt[i].mi);
      chk($sformatf("vec%0d", i), vt[i].es, vt[i].em, vt[i].ec, vt[i].er);
    end

    // Asynchronous reset mid-run at 12:34, then reload.
    do_reset();
    step(0, 1, 0, 0);
    chk("post_rst_reset", 6'd0, 6'd0, 1'b0, 1'b0);
    step(0, 1, 0, 0);
    chk("wait_tick1", 6'd0, 6'd0, 1'b0, 1'b0);
    step(0, 1, 0, 0);
    chk("wait_tick2", 6'd0, 6'd0, 1'b0, 1'b0);
    step(1, 0, 5, 7);
    chk("reload_5_7", 6'd5, 6'd7, 1'b0, 1'b1);
    for (int k = 0; k < 54; k++) step(0, 1, 0, 0);
    chk("run_to_59_7", 6'd59, 6'd7, 1'b0, 1'b1);
    step(0, 1, 0, 0);
    chk("carry_to_0_8", 6'd0, 6'd8, 1'b0, 1'b1);
`else
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wait_idle", 6'd0, 6'd0, 1'b0, 1'b0);
    step(1, 0, 58, 59);
    chk("pre_load", 6'd58, 6'd59, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step(0, 1, 0, 0);
      if (k < 4)
        chk($sformatf("pre_clk%0d", k), 6'd58, 6'd59, 1'b0, 1'b1);
      else if (k < 8)
        chk($sformatf("pre_clk%0d", k), 6'd59, 6'd59, 1'b0, 1'b1);
      else if (k == 8)
        chk("pre_clk8", 6'd0, 6'd0, 1'b1, 1'b1);
      else
        chk("pre_clk9", 6'd0, 6'd0, 1'b0, 1'b1);
    end
    step(1, 0, 10, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 20, 2);
    chk("pre_reload", 6'd20, 6'd2, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      if (k < 4)
        chk($sformatf("pre_rl%0d", k), 6'd20, 6'd2, 1'b0, 1'b1);
      else
        chk("pre_rl4", 6'd21, 6'd2, 1'b0, 1'b1);
    end
    do_reset();
    step(0, 0, 0, 0);
    chk("pre_post_rst", 6'd0, 6'd0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
